// File: rtl/pmem_pkg.sv
// Shared types and constants for the pmem responder slice.
package pmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/pmem_array.sv
// Single-port word array with synchronous write and registered read.
// The read register returns zero on any cycle without a read strobe, so its
// output can drive the responder's pmem_rdata directly.
module pmem_array
    import pmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

    // Select the word to register: the addressed entry on a read, else zero.
    always_comb begin
        rdata_d = {WORD_W{1'b0}};
        if (re) begin
            rdata_d = mem_q[idx];
        end else begin
            rdata_d = {WORD_W{1'b0}};
        end
    end

    // Storage update; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    // Read data register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= {WORD_W{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pmem_responder.sv
// Memory-side responder for the pmem_read/pmem_write/pmem_resp protocol.
// One outstanding request, fixed LATENCY cycles from acceptance to a one-cycle
// pmem_resp. Optional protocol checker enabled by macro PMEM_PROTO_CHECK_EN.
module pmem_responder
    import pmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [WORD_W-1:0] pmem_address,
    input  logic [WORD_W-1:0] pmem_wdata,
    output logic [WORD_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              proto_err
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    op_e                     op_q, op_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;
    logic                    resp_q, resp_d;
    logic                    mem_we_s;
    logic                    mem_re_s;
    logic                    addr_unused_s;

    // Address bits outside the word index are ignored (sub-word and alias bits).
    assign addr_unused_s = ^{pmem_address[WORD_W-1:ADDR_WIDTH+2], pmem_address[1:0]};

    // Next-state, counter and request latch. In IDLE the *_d values carry the
    // incoming request, so they also address the array when LATENCY is 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    op_d    = pmem_write ? OP_WR : OP_RD;
                    idx_d   = pmem_address[ADDR_WIDTH+1:2];
                    wdata_d = pmem_wdata;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        resp_d = (state_d == RESP);
    end

    // Array strobes fire on the edge entering RESP; reset suppresses a pending write.
    assign mem_we_s = resp_d && (op_d == OP_WR) && !rst;
    assign mem_re_s = resp_d && (op_d == OP_RD);

    // FSM and request-latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= OP_RD;
            idx_q   <= {ADDR_WIDTH{1'b0}};
            wdata_q <= {WORD_W{1'b0}};
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
        end
    end

    pmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we_s),
        .re   (mem_re_s),
        .idx  (idx_d),
        .wdata(wdata_d),
        .rdata(pmem_rdata)
    );

    assign pmem_resp = resp_q;

`ifdef PMEM_PROTO_CHECK_EN
    logic [WORD_W-1:0] addr_q, addr_d;
    logic              req_held_s;
    logic              viol_both_s;
    logic              viol_busy_s;
    logic              proto_err_q, proto_err_d;

    // Violation detection: simultaneous read/write, or a request that changes
    // or drops while the transaction is in flight.
    always_comb begin
        addr_d = addr_q;
        if ((state_q == IDLE) && (pmem_read || pmem_write)) begin
            addr_d = pmem_address;
        end else begin
            addr_d = addr_q;
        end
        req_held_s  = (op_q == OP_WR) ? pmem_write : pmem_read;
        viol_both_s = pmem_read && pmem_write;
        viol_busy_s = (state_q == BUSY) &&
                      (!req_held_s || (pmem_address != addr_q) || (pmem_wdata != wdata_q));
        proto_err_d = proto_err_q || viol_both_s || viol_busy_s;
    end

    // Full-address latch and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= {WORD_W{1'b0}};
            proto_err_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;

`ifndef SYNTHESIS
    logic [31:0] cyc_q;

    // Simulation-only cycle stamp and violation report.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= 32'd0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (viol_both_s || viol_busy_s) begin
                $error("pmem protocol violation at cycle %0d", cyc_q);
            end
        end
    end
`endif
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed self-checking bench: LATENCY=3 instance for the main sequence and a
// LATENCY=1 instance for back-to-back responses.
module tb_pmem_responder;

`ifdef PMEM_PROTO_CHECK_EN
    localparam logic PERR_ON = 1'b1;
`else
    localparam logic PERR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [31:0] rdata;
    logic        resp, perr;
    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr1 = 32'd0, wdata1 = 32'd0;
    logic [31:0] rdata1;
    logic        resp1, perr1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pmem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut (
        .clk(clk), .rst(rst), .pmem_read(rd), .pmem_write(wr),
        .pmem_address(addr), .pmem_wdata(wdata), .pmem_rdata(rdata),
        .pmem_resp(resp), .proto_err(perr)
    );

    pmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .pmem_read(rd1), .pmem_write(wr1),
        .pmem_address(addr1), .pmem_wdata(wdata1), .pmem_rdata(rdata1),
        .pmem_resp(resp1), .proto_err(perr1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on the LATENCY=3 instance, issued in cycle T; checks resp
    // only at T+3 and rdata zero outside the response cycle.
    task automatic txn3(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
        rd = r; wr = w; addr = a; wdata = d;
        chk({tag, " resp@T"}, {31'd0, resp}, 32'd0);
        tick();
        chk({tag, " resp@T+1"}, {31'd0, resp}, 32'd0);
        chk({tag, " rdata@T+1"}, rdata, 32'd0);
        tick();
        chk({tag, " resp@T+2"}, {31'd0, resp}, 32'd0);
        chk({tag, " rdata@T+2"}, rdata, 32'd0);
        tick();
        chk({tag, " resp@T+3"}, {31'd0, resp}, 32'd1);
        chk({tag, " rdata@T+3"}, rdata, exp_rd);
        rd = 1'b0; wr = 1'b0;
        tick();
        chk({tag, " resp@T+4"}, {31'd0, resp}, 32'd0);
        chk({tag, " rdata@T+4"}, rdata, 32'd0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst resp", {31'd0, resp}, 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst perr", {31'd0, perr}, 32'd0);
        chk("rst resp1", {31'd0, resp1}, 32'd0);
        rst = 1'b0;
        tick();

        // LATENCY=1: single write, then a read held across two transactions
        wr1 = 1'b1; addr1 = 32'h0000_0008; wdata1 = 32'h55AA_00FF;
        tick();
        chk("l1 wr resp", {31'd0, resp1}, 32'd1);
        chk("l1 wr rdata", rdata1, 32'd0);
        wr1 = 1'b0;
        tick();
        chk("l1 wr idle", {31'd0, resp1}, 32'd0);
        rd1 = 1'b1;
        tick();
        chk("l1 rd1 resp", {31'd0, resp1}, 32'd1);
        chk("l1 rd1 data", rdata1, 32'h55AA_00FF);
        tick();
        chk("l1 gap resp", {31'd0, resp1}, 32'd0);
        chk("l1 gap data", rdata1, 32'd0);
        tick();
        chk("l1 rd2 resp", {31'd0, resp1}, 32'd1);
        chk("l1 rd2 data", rdata1, 32'h55AA_00FF);
        rd1 = 1'b0;
        tick();
        chk("l1 end resp", {31'd0, resp1}, 32'd0);

        // Write then read back, low address bits ignored
        txn3(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, "wr10");
        txn3(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, "rd10");
        txn3(1'b1, 1'b0, 32'h0000_0013, 32'd0, 32'hDEAD_BEEF, "rd13");

        // Aliasing modulo 2**12 bytes
        txn3(1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 32'd0, "wr1000");
        txn3(1'b1, 1'b0, 32'h0000_0000, 32'd0, 32'h1234_5678, "rd0alias");

        // Reset in BUSY discards a pending write
        txn3(1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, 32'd0, "wr20");
        wr = 1'b1; addr = 32'h0000_0020; wdata = 32'hAAAA_5555;
        tick();
        rst = 1'b1; wr = 1'b0;
        tick();
        chk("abort resp a", {31'd0, resp}, 32'd0);
        rst = 1'b0;
        tick();
        chk("abort resp b", {31'd0, resp}, 32'd0);
        tick();
        chk("abort resp c", {31'd0, resp}, 32'd0);
        txn3(1'b1, 1'b0, 32'h0000_0020, 32'd0, 32'h1111_2222, "rd20");

        // Request dropped during BUSY
        rd = 1'b1; addr = 32'h0000_0010;
        tick();
        rd = 1'b0;
        tick();
        chk("drop perr", {31'd0, perr}, {31'd0, PERR_ON});
        chk("drop resp T+2", {31'd0, resp}, 32'd0);
        tick();
        chk("drop resp T+3", {31'd0, resp}, 32'd1);
        chk("drop rdata", rdata, 32'hDEAD_BEEF);
        tick();
        chk("drop resp T+4", {31'd0, resp}, 32'd0);
        txn3(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, "clean");
        chk("perr sticky", {31'd0, perr}, {31'd0, PERR_ON});

        // Read and write together: write wins
        txn3(1'b1, 1'b1, 32'h0000_0040, 32'h0F0F_0F0F, 32'd0, "both40");
        txn3(1'b1, 1'b0, 32'h0000_0040, 32'd0, 32'h0F0F_0F0F, "rd40");
        chk("both perr", {31'd0, perr}, {31'd0, PERR_ON});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("perr cleared", {31'd0, perr}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
